uart_tx_frame: RTL

//  Parametrised UART transmitter: serialises one DATA_BITS word per valid/ready handshake

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_tick.sv | 25 ++
 rtl/uart_tx_frame.sv | 134 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers: FSM state encoding, baud divisor calculation and
// legal parameter ranges. Used by both the TX and RX sides of the serial link.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

    // Integer floor of clock cycles per bit.
    function automatic int calc_divisor(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time clock enable: counts while enable is high and pulses tick on count DIVISOR-1.
// A synchronous clear realigns the phase to the moment a frame is accepted.
module uart_baud_tick #(
    parameter int DIVISOR = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == CW'(DIVISOR - 1));

    always_ff @(posedge clock) begin
        if (reset || clear)
            cnt <= '0;
        else if (enable)
            cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/uart_tx_frame.sv
// Handshaked UART transmitter: start, DATA_BITS LSB first, optional parity, 1-2 stop bits.
// Define UART_TX_PARITY_EN to add a parity bit (even, or odd when PARITY_ODD=1).
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int BAUDRATE    = 115200,
    parameter int CLOCK_INPUT = 50_000_000,
    parameter int PARITY_ODD  = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 valid,
    input  logic [DATA_BITS-1:0] data,
    output logic                 ready,
    output logic                 sdata,
    output logic                 busy,
    output logic                 done
);
    localparam int DIVISOR = calc_divisor(CLOCK_INPUT, BAUDRATE);
    localparam int IW      = $clog2(DATA_BITS);

    if (DIVISOR < 2 || DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
        STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_err
        $error("uart_tx_frame: illegal parameters (DIVISOR=%0d)", DIVISOR);
    end

    uart_tx_state_t       state;
    logic [DATA_BITS-1:0] shift;
    logic [IW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic                 tick;
    logic                 accept;
`ifdef UART_TX_PARITY_EN
    logic                 par;
`endif

    assign accept = valid && ready;

    uart_baud_tick #(.DIVISOR(DIVISOR)) u_baud (
        .clock  (clock),
        .reset  (reset),
        .enable (busy),
        .clear  (accept),
        .tick   (tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            sdata    <= 1'b1;
            ready    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            shift    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift <= data;
`ifdef UART_TX_PARITY_EN
                        par   <= ^data ^ 1'(PARITY_ODD);
`endif
                        state <= START;
                        sdata <= 1'b0;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        sdata   <= shift[0];
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == IW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state    <= PARITY;
                            sdata    <= par;
`else
                            state    <= STOP;
                            sdata    <= 1'b1;
`endif
                            stop_cnt <= 1'b0;
                        end else begin
                            // sdata follows the bit that becomes shift[0] after this shift
                            bit_cnt <= bit_cnt + 1'b1;
                            shift   <= shift >> 1;
                            sdata   <= shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state <= STOP;
                        sdata <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (stop_cnt == 1'(STOP_BITS - 1)) begin
                            state <= IDLE;
                            done  <= 1'b1;
                            ready <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    sdata <= 1'b1;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
